// File: rtl/vslc_timer_pkg.sv
// vslc_timer_pkg
// Shared types and constants for the VSLC timer arbiter slice.
//   timer_state_e      : sequencer states (IDLE, LOAD, PHASE_A, PHASE_B, DONE)
//   TIMER_MODE_*       : per-requester mode encoding (CYCLE / ONESHOT)
//   *_DEF              : default widths used by the interface and top
//   PRESCALE_W         : fixed width of the tick prescaler
package vslc_timer_pkg;

  localparam int NREQ_DEF     = 4;
  localparam int PERIOD_W_DEF = 16;
  localparam int DIV_W_DEF    = 4;
  localparam int PRESCALE_W   = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PHASE_A = 3'd2,
    PHASE_B = 3'd3,
    DONE    = 3'd4
  } timer_state_e;

  localparam logic TIMER_MODE_CYCLE   = 1'b0;
  localparam logic TIMER_MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/vslc_timer_arbiter_if.sv
// vslc_timer_arbiter_if
// Request/config/status bundle between requesters and the shared timer.
//   req          : per-requester level request
//   cfg_period_a : packed high-phase tick counts, slice i = requester i
//   cfg_period_b : packed low-phase tick counts
//   cfg_div      : packed divisor exponents (tick = 2^div clocks)
//   cfg_mode     : per-requester mode, 0 = CYCLE, 1 = ONESHOT
//   grant        : one-hot owner
//   done         : one-cycle release pulse to the owner
//   busy         : timer sequencer not idle
//   timer_out    : timer waveform
// Modports: master = requester side, slave = arbiter side.
interface vslc_timer_arbiter_if
  import vslc_timer_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DIV_W    = DIV_W_DEF
) ();

  logic [NREQ-1:0]          req;
  logic [NREQ*PERIOD_W-1:0] cfg_period_a;
  logic [NREQ*PERIOD_W-1:0] cfg_period_b;
  logic [NREQ*DIV_W-1:0]    cfg_div;
  logic [NREQ-1:0]          cfg_mode;
  logic [NREQ-1:0]          grant;
  logic [NREQ-1:0]          done;
  logic                     busy;
  logic                     timer_out;

  modport master (
    output req, cfg_period_a, cfg_period_b, cfg_div, cfg_mode,
    input  grant, done, busy, timer_out
  );

  modport slave (
    input  req, cfg_period_a, cfg_period_b, cfg_div, cfg_mode,
    output grant, done, busy, timer_out
  );

endinterface

// File: rtl/vslc_rr_arbiter.sv
// vslc_rr_arbiter
// Combinational request picker.
//   req   : request vector
//   ptr   : round-robin start index (absent when fixed priority is built)
//   gnt   : one-hot winner
//   idx   : binary winner index
//   valid : at least one request set
// Build option VSLC_TIMER_FIXED_PRIO_EN: lowest index wins, no pointer port.
module vslc_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
`ifndef VSLC_TIMER_FIXED_PRIO_EN
  input  logic [IDX_W-1:0] ptr,
`endif
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    // Scan from the lowest-priority candidate upward so the last hit,
    // i.e. the highest-priority one, is what remains.
`ifdef VSLC_TIMER_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
        valid  = 1'b1;
      end
    end
`else
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        valid  = 1'b1;
      end
    end
`endif
  end

endmodule

// File: rtl/vslc_timer_arbiter.sv
// vslc_timer_arbiter
// Shares one PWM/one-shot timer between NREQ requesters. A winner is picked,
// its config is latched, the timer is sequenced through its high/low phases
// and the owner gets a done pulse on release.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : vslc_timer_arbiter_if.slave (req/cfg in, grant/done/busy/timer_out out)
// Build option VSLC_TIMER_FIXED_PRIO_EN: fixed priority (lowest index wins),
// no round-robin pointer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no owner; arbitrate among requests
// LOAD    | owner granted; latch its config, clear counters
// PHASE_A | timer_out high for period_a ticks
// PHASE_B | timer_out low for period_b ticks
// DONE    | one-cycle done pulse to owner, advance rr pointer
module vslc_timer_arbiter
  import vslc_timer_pkg::*;
#(
  parameter int NREQ     = NREQ_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DIV_W    = DIV_W_DEF
) (
  input logic                 clk,
  input logic                 rst,
  vslc_timer_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);

  timer_state_e state_q, state_d;

  logic [IDX_W-1:0]      owner_idx_q;
  logic [NREQ-1:0]       owner_oh_q;
  logic [PERIOD_W-1:0]   period_a_q, period_b_q;
  logic [DIV_W-1:0]      div_q;
  logic                  mode_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic [PERIOD_W-1:0]   cnt_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;

  logic [NREQ-1:0] grant_c, done_c;
  logic            busy_c, timer_out_c;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
`ifndef VSLC_TIMER_FIXED_PRIO_EN
  logic [IDX_W-1:0] rr_ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (state_q == DONE) begin
      rr_ptr_q <= (owner_idx_q == IDX_W'(NREQ - 1)) ? '0 : owner_idx_q + IDX_W'(1);
    end
  end
`endif

  vslc_rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (bus.req),
`ifndef VSLC_TIMER_FIXED_PRIO_EN
    .ptr   (rr_ptr_q),
`endif
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // ---------------------------------------------------------------------
  // Owner config views and tick/phase-end detection
  // ---------------------------------------------------------------------
  // LOAD decides the first phase from the live config, since the latched
  // copy only becomes valid at the end of LOAD.
  logic [PERIOD_W-1:0] sel_period_a, sel_period_b;
  logic [DIV_W-1:0]    sel_div;
  logic                sel_mode;

  assign sel_period_a = bus.cfg_period_a[int'(owner_idx_q)*PERIOD_W +: PERIOD_W];
  assign sel_period_b = bus.cfg_period_b[int'(owner_idx_q)*PERIOD_W +: PERIOD_W];
  assign sel_div      = bus.cfg_div[int'(owner_idx_q)*DIV_W +: DIV_W];
  assign sel_mode     = bus.cfg_mode[owner_idx_q];

  logic [PRESCALE_W-1:0] pre_last;
  logic [PERIOD_W-1:0]   cur_period;
  logic                  tick, phase_end, cycle_abort;

  assign pre_last    = PRESCALE_W'((32'd1 << div_q) - 32'd1);
  assign tick        = (pre_q == pre_last);
  assign cur_period  = (state_q == PHASE_B) ? period_b_q : period_a_q;
  assign phase_end   = tick && (cnt_q == cur_period - PERIOD_W'(1));
  // A CYCLE owner keeps the timer only while it holds its request.
  assign cycle_abort = (mode_q == TIMER_MODE_CYCLE) && !bus.req[owner_idx_q];

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (arb_valid) state_d = LOAD;
      end
      LOAD: begin
        if (sel_period_a != '0)      state_d = PHASE_A;
        else if (sel_period_b != '0) state_d = PHASE_B;
        else                         state_d = DONE;
      end
      PHASE_A: begin
        if (cycle_abort) begin
          state_d = DONE;
        end else if (phase_end) begin
          if (period_b_q != '0)                  state_d = PHASE_B;
          else if (mode_q == TIMER_MODE_ONESHOT) state_d = DONE;
          else                                   state_d = PHASE_A;
        end
      end
      PHASE_B: begin
        if (cycle_abort) begin
          state_d = DONE;
        end else if (phase_end) begin
          if (mode_q == TIMER_MODE_ONESHOT) state_d = DONE;
          else if (period_a_q != '0)        state_d = PHASE_A;
          else                              state_d = PHASE_B;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------
  always_comb begin
    grant_c     = '0;
    done_c      = '0;
    busy_c      = 1'b0;
    timer_out_c = 1'b0;
    case (state_q)
      LOAD, PHASE_B: begin
        grant_c = owner_oh_q;
        busy_c  = 1'b1;
      end
      PHASE_A: begin
        grant_c     = owner_oh_q;
        busy_c      = 1'b1;
        timer_out_c = 1'b1;
      end
      DONE: begin
        done_c = owner_oh_q;
        busy_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.grant     = grant_c;
  assign bus.done      = done_c;
  assign bus.busy      = busy_c;
  assign bus.timer_out = timer_out_c;

  // ---------------------------------------------------------------------
  // Owner, config latch and counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_idx_q <= '0;
      owner_oh_q  <= '0;
      period_a_q  <= '0;
      period_b_q  <= '0;
      div_q       <= '0;
      mode_q      <= TIMER_MODE_CYCLE;
      pre_q       <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (arb_valid) begin
            owner_idx_q <= arb_idx;
            owner_oh_q  <= arb_gnt;
          end
        end
        LOAD: begin
          period_a_q <= sel_period_a;
          period_b_q <= sel_period_b;
          div_q      <= sel_div;
          mode_q     <= sel_mode;
          pre_q      <= '0;
          cnt_q      <= '0;
        end
        PHASE_A, PHASE_B: begin
          if (phase_end) begin
            pre_q <= '0;
            cnt_q <= '0;
          end else if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_q + PERIOD_W'(1);
          end else begin
            pre_q <= pre_q + PRESCALE_W'(1);
          end
        end
        DONE: begin
          pre_q <= '0;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
